// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and port indices for the write-back arbiter
package wb_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam logic PORT_ALU = 1'b0;
  localparam logic PORT_MC = 1'b1;
endpackage

// File: rtl/wb_port_arb_if.sv
// wb_port_arb_if: two requester ports (valid/ready/addr/data) plus register-file write port and busy; slave = arbiter, master = requesters
interface wb_port_arb_if import wb_pkg::*; #(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) ();
  logic              in0_valid, in1_valid;
  logic              in0_ready, in1_ready;
  logic [ADDR_W-1:0] in0_addr, in1_addr;
  logic [DATA_W-1:0] in0_data, in1_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  modport master (
    output in0_valid, in0_addr, in0_data, in1_valid, in1_addr, in1_data,
    input  in0_ready, in1_ready, wr_en, wr_addr, wr_data, busy
  );
  modport slave (
    input  in0_valid, in0_addr, in0_data, in1_valid, in1_addr, in1_data,
    output in0_ready, in1_ready, wr_en, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/MUX2_n.sv
// MUX2_n: N-bit two-input mux (a, b, s -> y), y = s ? b : a
module MUX2_n #(
  parameter int N = 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         s,
  output logic [N-1:0] y
);
  assign y = s ? b : a;
endmodule

// File: rtl/wb_slot.sv
// wb_slot: one-entry write buffer (clk, reset, load/clr strobes, addr_i/data_i in; full/addr/data out)
module wb_slot import wb_pkg::*; #(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  always_comb begin
    full_d = load ? 1'b1 : clr ? 1'b0 : full_q;
    addr_d = load ? addr_i : addr_q;
    data_d = load ? data_i : data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign full = full_q;
  assign addr = addr_q;
  assign data = data_q;
endmodule

// File: rtl/wb_port_arb.sv
// wb_port_arb: round-robin write-back arbiter (clk, reset, bus slave modport); WB_ARB_ZERO_FILTER_EN drains addr-0 entries without wr_en
module wb_port_arb import wb_pkg::*; #(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input logic         clk,
  input logic         reset,
  wb_port_arb_if.slave bus
);
  logic              full0, full1, both, any, g;
  logic [ADDR_W-1:0] addr0, addr1, sel_addr;
  logic [DATA_W-1:0] data0, data1, sel_data;
  logic              wr_en_q, wr_en_d, rr_q, rr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  assign both = full0 && full1;
  assign any = full0 || full1;
  // port 1 wins when it is alone, or when contended and rr points at it
  assign g = full1 && (!full0 || rr_q == PORT_MC);
  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
    .clk(clk), .reset(reset),
    .load(bus.in0_valid && !full0), .clr(full0 && g == PORT_ALU),
    .addr_i(bus.in0_addr), .data_i(bus.in0_data),
    .full(full0), .addr(addr0), .data(data0)
  );
  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
    .clk(clk), .reset(reset),
    .load(bus.in1_valid && !full1), .clr(full1 && g == PORT_MC),
    .addr_i(bus.in1_addr), .data_i(bus.in1_data),
    .full(full1), .addr(addr1), .data(data1)
  );
  MUX2_n #(.N(ADDR_W)) u_mux_addr (.a(addr0), .b(addr1), .s(g), .y(sel_addr));
  MUX2_n #(.N(DATA_W)) u_mux_data (.a(data0), .b(data1), .s(g), .y(sel_data));
  always_comb begin
`ifdef WB_ARB_ZERO_FILTER_EN
    wr_en_d = any && (sel_addr != '0);
`else
    wr_en_d = any;
`endif
    wr_addr_d = wr_en_d ? sel_addr : wr_addr_q;
    wr_data_d = wr_en_d ? sel_data : wr_data_q;
    rr_d = both ? !g : rr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rr_q <= PORT_ALU;
    end else begin
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rr_q <= rr_d;
    end
  end
  assign bus.in0_ready = !full0;
  assign bus.in1_ready = !full1;
  assign bus.wr_en = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy = full0 || full1 || wr_en_q;
endmodule

// File: tb/tb_wb_port_arb.sv
// tb_wb_port_arb: scoreboard bench for wb_port_arb against a queue-based reference model
module tb_wb_port_arb;
  import wb_pkg::*;
  localparam int DW = 32;
  localparam int AW = 5;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  wb_port_arb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  wb_port_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  wr_t pq[2][$];
  wr_t sb[$];
  int rr_m = 0;
  bit exp_wr = 1'b0;
  wr_t last = '0;
  bit chk_en = 1'b0;
  function automatic bit keep(wr_t e);
`ifdef WB_ARB_ZERO_FILTER_EN
    return e.a != '0;
`else
    return 1'b1;
`endif
  endfunction
  task automatic check(string n, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // reference: each port holds at most one pending write; grant the only
  // pending port, or the favoured one when both wait, then favour the other
  always @(posedge clk) begin
    int g;
    bit acc0, acc1;
    wr_t e;
    if (reset) begin
      pq[0].delete();
      pq[1].delete();
      sb.delete();
      rr_m = 0;
      exp_wr = 1'b0;
      last = '0;
    end else begin
      acc0 = bus.in0_valid && pq[0].size() == 0;
      acc1 = bus.in1_valid && pq[1].size() == 0;
      g = -1;
      if (pq[0].size() != 0 && pq[1].size() != 0) begin
        g = rr_m;
        rr_m = 1 - g;
      end else if (pq[0].size() != 0) g = 0;
      else if (pq[1].size() != 0) g = 1;
      exp_wr = 1'b0;
      if (g >= 0) begin
        e = pq[g].pop_front();
        if (keep(e)) begin
          exp_wr = 1'b1;
          last = e;
          sb.push_back(e);
        end
      end
      if (acc0) pq[0].push_back({bus.in0_addr, bus.in0_data});
      if (acc1) pq[1].push_back({bus.in1_addr, bus.in1_data});
    end
  end
  always @(negedge clk) begin
    wr_t e;
    if (chk_en) begin
      check("in0_ready", 64'(bus.in0_ready), 64'(pq[0].size() == 0));
      check("in1_ready", 64'(bus.in1_ready), 64'(pq[1].size() == 0));
      check("busy", 64'(bus.busy), 64'(pq[0].size() != 0 || pq[1].size() != 0 || exp_wr));
      check("wr_en", 64'(bus.wr_en), 64'(exp_wr));
      check("wr_addr", 64'(bus.wr_addr), 64'(last.a));
      check("wr_data", 64'(bus.wr_data), 64'(last.d));
      if (bus.wr_en) begin
        if (sb.size() == 0) check("sb_empty", 64'(1), 64'(0));
        else begin
          e = sb.pop_front();
          check("sb_write", 64'({bus.wr_addr, bus.wr_data}), 64'(e));
        end
      end
    end
  end
  task automatic drive(bit r, bit v0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                       bit v1, logic [AW-1:0] a1, logic [DW-1:0] d1);
    @(negedge clk);
    reset = r;
    bus.in0_valid = v0;
    bus.in0_addr = a0;
    bus.in0_data = d0;
    bus.in1_valid = v1;
    bus.in1_addr = a1;
    bus.in1_data = d1;
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, AW'($urandom), $urandom, 1'b0, AW'($urandom), $urandom);
  endtask
  initial begin
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in0_addr = '0;
    bus.in1_addr = '0;
    bus.in0_data = '0;
    bus.in1_data = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    drive(1'b1, 1'b1, 5'h07, 32'h1234, 1'b1, 5'h08, 32'h5678);
    idle(2);
    drive(1'b0, 1'b1, 5'h03, 32'h0000_0011, 1'b0, 5'h00, 32'h0);
    idle(4);
    drive(1'b0, 1'b1, 5'h01, 32'hAAAA_AAAA, 1'b1, 5'h02, 32'h5555_5555);
    idle(4);
    for (int i = 0; i < 8; i++)
      drive(1'b0, 1'b1, AW'(i), 32'h100 + i, 1'b1, AW'(i + 16), 32'h200 + i);
    idle(4);
    for (int i = 0; i < 6; i++)
      drive(1'b0, 1'b0, 5'h00, 32'h0, 1'b1, 5'h09, 32'h300 + i);
    idle(4);
    drive(1'b0, 1'b1, 5'h04, 32'hDEAD_0004, 1'b1, 5'h05, 32'hDEAD_0005);
    drive(1'b1, 1'b1, 5'h06, 32'hDEAD_0006, 1'b1, 5'h07, 32'hDEAD_0007);
    idle(3);
    drive(1'b0, 1'b1, 5'h00, 32'hFFFF_FFFF, 1'b0, 5'h00, 32'h0);
    idle(4);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 2) != 0, AW'($urandom_range(0, 31)), $urandom);
    idle(4);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_port_arb.md
WB_PORT_ARB -- requirements
Module: wb_port_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: write-back data width.
REQ-002 SHALL have parameter ADDR_W, default 5: register-file address width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have ports in0_valid, in1_valid  input  1: requester 0 (ALU pipe) / requester 1 (multi-cycle unit) offer a write.
REQ-006 SHALL have ports in0_ready, in1_ready  output  1: port can accept; driven from registered state only.
REQ-007 SHALL have ports in0_addr, in1_addr  input  ADDR_W: destination register.
REQ-008 SHALL have ports in0_data, in1_data  input  DATA_W: write data.
REQ-009 SHALL have port wr_en  output  1: register-file write strobe.
REQ-010 SHALL have port wr_addr  output  ADDR_W, and port wr_data  output  DATA_W: registered write address and data.
REQ-011 SHALL have port busy  output  1: any input buffer full or wr_en high.

Function
REQ-012 SHALL hold one one-entry buffer per port (full flag, addr, data); inN_ready = !fullN.
REQ-013 SHALL transfer on a port when inN_valid && inN_ready at a clock edge; the buffer becomes full at that edge.
REQ-014 SHALL arbitrate each cycle among full buffers: a single full buffer is granted; if both are full, the round-robin pointer rr selects the port.
REQ-015 SHALL, on grant, copy the granted buffer into wr_addr/wr_data, assert wr_en for exactly one cycle, and clear that buffer at the same edge.
REQ-016 SHALL toggle rr to the non-granted port only when both buffers were full; an uncontended grant leaves rr unchanged.
REQ-017 SHALL give latency of exactly 2 cycles uncontended: accepted at edge N -> wr_en high in cycle after edge N+1.
REQ-018 SHALL bound wait: a full buffer is granted within 2 arbitration cycles.
REQ-019 SHALL not accept on a port in the same cycle its buffer drains (ready is registered); per-port throughput is 1 write per 2 cycles.
REQ-020 SHALL deassert wr_en when no buffer is full; wr_addr/wr_data hold their last values.
REQ-021 SHALL not reorder same-port writes; cross-port same-address ordering follows grant order; hazard avoidance is the issuer's responsibility.
REQ-022 SHALL ignore inN_addr/inN_data when no transfer occurs.

Reset
REQ-023 SHALL, while reset is high at an edge: clear both full flags, wr_en=0, wr_addr=0, wr_data=0, rr=0 (port 0 favoured), busy=0.
REQ-024 SHALL discard buffered and in-flight writes when reset is asserted mid-operation; no wr_en in the cycle after reset.
REQ-025 SHALL ignore inN_valid during reset; in0_ready=in1_ready=1 in the first cycle after reset.

Configuration
REQ-026 SHALL recognise macro WB_ARB_ZERO_FILTER_EN.
REQ-027 SHALL, with WB_ARB_ZERO_FILTER_EN defined, accept and drain a granted entry with addr 0 normally (buffer clears, rr rules apply) but keep wr_en low for it.
REQ-028 SHALL, without the macro, forward addr-0 writes to the write port like any other address.

Structure
REQ-029 SHALL take DATA_W/ADDR_W defaults from localparams in shared package wb_pkg, which also defines the port-index constants (PORT_ALU=0, PORT_MC=1).
REQ-030 SHALL implement each input buffer as sub-module wb_slot (full flag + addr/data register, load/clear strobes), instantiated twice.
REQ-031 SHALL build the output data/address select with the std-lib MUX2_n gates.

Verification
REQ-032 Single write: in0 valid, addr=5'h03, data=32'h0000_0011 for 1 cycle -> wr_en one cycle, 2 cycles later, wr_addr=03, wr_data=0000_0011.
REQ-033 Contention: both ports load same cycle (in0 addr 1 data AAAA_AAAA, in1 addr 2 data 5555_5555) -> port 0 written first, port 1 next cycle, rr=1 afterwards.
REQ-034 Fairness: both valid continuously for 8 cycles -> grants alternate 0,1,0,1; no port waits more than 2 cycles.
REQ-035 Backpressure: in1 valid held while buffer full -> in1_ready=0, no duplicate write, data accepted exactly once per ready cycle.
REQ-036 Reset mid-operation: both buffers full, reset pulsed 1 cycle -> no wr_en afterwards, both ready=1, busy=0.
REQ-037 Zero filter: addr=5'h00 data=FFFF_FFFF on in0 -> with WB_ARB_ZERO_FILTER_EN wr_en stays 0 and in0_ready returns to 1; without it wr_en=1, wr_addr=00.
